// File: rtl/alu_iter.sv
// alu_iter: multi-cycle execute unit. Logic/arithmetic ops finish in one cycle;
// SLL/SRL run through a serial shifter that moves one bit per clock.
module alu_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSll = 4'b0011;
    localparam logic [3:0] OpNor = 4'b0100;
    localparam logic [3:0] OpSrl = 4'b0101;
    localparam logic [3:0] OpSub = 4'b0110;
    localparam logic [3:0] OpSlt = 4'b0111;
    localparam logic [3:0] OpXor = 4'b1000;

    typedef enum logic [0:0] {StIdle, StShift} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [SHW-1:0]     count_q, count_d;
    logic               left_q, left_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               illegal_q, illegal_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_ill;
    logic               is_shift;
    logic [WIDTH-1:0]   shifted;

    assign is_shift = (alucontrol == OpSll) || (alucontrol == OpSrl);
    assign shifted  = left_q ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

    // Single-cycle ALU; shift codes only reach here with shamt=0, so they pass b.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (alucontrol)
            OpAnd:   alu_res = a & b;
            OpOr:    alu_res = a | b;
            OpAdd:   alu_res = a + b;
            OpSll:   alu_res = b;
            OpNor:   alu_res = ~(a | b);
            OpSrl:   alu_res = b;
            OpSub:   alu_res = a - b;
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OpXor:   alu_res = a ^ b;
            default: alu_ill = 1'b1;
        endcase
    end

    // Next-state logic: start is only honoured in StIdle, so requests while busy drop.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        count_d   = count_q;
        left_d    = left_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (is_shift && (shamt != '0)) begin
                        state_d = StShift;
                        shreg_d = b;
                        count_d = shamt;
                        left_d  = (alucontrol == OpSll);
                    end else begin
                        result_d  = alu_res;
                        zero_d    = (alu_res == '0);
                        illegal_d = alu_ill;
                        done_d    = 1'b1;
                    end
                end
            end
            StShift: begin
                shreg_d = shifted;
                count_d = count_q - SHW'(1);
                if (count_q == SHW'(1)) begin
                    state_d   = StIdle;
                    result_d  = shifted;
                    zero_d    = (shifted == '0);
                    illegal_d = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset aborts any shift in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            count_q   <= '0;
            left_q    <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            count_q   <= count_d;
            left_q    <= left_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == StShift);
    assign done    = done_q;
    assign result  = result_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed self-checking bench for alu_iter.
module tb_alu_iter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SHW   = 5;

    logic             clk;
    logic             reset;
    logic             start;
    logic [3:0]       alucontrol;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    int n_checks;
    int n_errors;

    alu_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .alucontrol (alucontrol),
        .a          (a),
        .b          (b),
        .shamt      (shamt),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .zero       (zero),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present an op before an edge and pulse start for that edge; returns 1ns after it.
    task automatic issue(input logic [3:0] c, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [4:0] sh);
        @(negedge clk);
        start      = 1'b1;
        alucontrol = c;
        a          = ia;
        b          = ib;
        shamt      = sh;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges after the start edge until done (-1 on timeout) and busy samples before it.
    task automatic wait_done(input int limit, output int edges, output int busy_n);
        edges  = 0;
        busy_n = 0;
        while (!done && edges < limit) begin
            if (busy) busy_n++;
            @(posedge clk);
            #1;
            edges++;
        end
        if (!done) edges = -1;
    endtask

    initial begin
        int edges;
        int busy_n;
        int saw_done;

        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b0;
        start      = 1'b0;
        alucontrol = 4'b0000;
        a          = '0;
        b          = '0;
        shamt      = '0;

        // 1. reset held, then released
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_held_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_held_zero", {31'd0, zero}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_zero", {31'd0, zero}, 32'd1);
        check_eq("rst_illegal", {31'd0, illegal}, 32'd0);

        // 2. ADD overflow wrap, then back-to-back SUB in the done cycle
        issue(4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd0);
        check_eq("add_done", {31'd0, done}, 32'd1);
        check_eq("add_result", result, 32'h8000_0000);
        check_eq("add_zero", {31'd0, zero}, 32'd0);
        start      = 1'b1;
        alucontrol = 4'b0110;
        a          = 32'd5;
        b          = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("sub_done", {31'd0, done}, 32'd1);
        check_eq("sub_result", result, 32'd0);
        check_eq("sub_zero", {31'd0, zero}, 32'd1);
        @(posedge clk);
        #1;
        check_eq("sub_done_drop", {31'd0, done}, 32'd0);

        // 3. SLT signed, NOR, XOR
        issue(4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd0);
        check_eq("slt_neg_lt", result, 32'd1);
        issue(4'b0111, 32'h1, 32'hFFFF_FFFF, 5'd0);
        check_eq("slt_pos_ge", result, 32'd0);
        check_eq("slt_pos_zero", {31'd0, zero}, 32'd1);
        issue(4'b0100, 32'h0, 32'h0, 5'd0);
        check_eq("nor_result", result, 32'hFFFF_FFFF);
        issue(4'b1000, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd0);
        check_eq("xor_result", result, 32'h0F0F_F0F0);
        @(posedge clk);
        #1;
        check_eq("xor_hold", result, 32'h0F0F_F0F0);
        check_eq("xor_hold_done", {31'd0, done}, 32'd0);

        // 5. SRL by 4, then SRL by 0
        issue(4'b0101, 32'h0, 32'h8000_0000, 5'd4);
        wait_done(20, edges, busy_n);
        check_eq("srl4_latency", edges, 32'd4);
        check_eq("srl4_busy", busy_n, 32'd4);
        check_eq("srl4_result", result, 32'h0800_0000);
        issue(4'b0101, 32'h0, 32'h0000_1234, 5'd0);
        check_eq("srl0_busy", {31'd0, busy}, 32'd0);
        check_eq("srl0_done", {31'd0, done}, 32'd1);
        check_eq("srl0_result", result, 32'h0000_1234);

        // 6. illegal code, then AND clears illegal
        issue(4'b1011, 32'd3, 32'd4, 5'd0);
        check_eq("ill_done", {31'd0, done}, 32'd1);
        check_eq("ill_flag", {31'd0, illegal}, 32'd1);
        check_eq("ill_result", result, 32'd0);
        check_eq("ill_zero", {31'd0, zero}, 32'd1);
        issue(4'b0000, 32'hC, 32'hA, 5'd0);
        check_eq("and_result", result, 32'h8);
        check_eq("and_illegal", {31'd0, illegal}, 32'd0);

        // 4. SLL by 31 with an ignored start and operand changes mid-shift
        issue(4'b0011, 32'h0, 32'h0000_0001, 5'd31);
        check_eq("sll_busy_start", {31'd0, busy}, 32'd1);
        edges  = 0;
        busy_n = 0;
        while (!done && edges < 40) begin
            if (busy) busy_n++;
            if (edges == 10) begin
                start      = 1'b1;
                alucontrol = 4'b0010;
                a          = 32'd5;
                b          = 32'd7;
                shamt      = 5'd0;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            edges++;
        end
        if (!done) edges = -1;
        check_eq("sll_latency", edges, 32'd31);
        check_eq("sll_busy", busy_n, 32'd31);
        check_eq("sll_result", result, 32'h8000_0000);
        check_eq("sll_busy_end", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("sll_no_queue", {31'd0, done}, 32'd0);
        check_eq("sll_hold", result, 32'h8000_0000);

        // 1b. reset asserted mid-shift
        issue(4'b0011, 32'h0, 32'h0000_0001, 5'd20);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        check_eq("abort_result", result, 32'd0);
        check_eq("abort_zero", {31'd0, zero}, 32'd1);
        @(negedge clk);
        reset    = 1'b1;
        saw_done = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1;
        end
        check_eq("abort_no_done", saw_done, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Multi-cycle execute unit for the MIPS datapath.
- Consumes the 4-bit alucontrol code produced by the ALU decoder, plus A/B operands and the shift amount.
- Logic and arithmetic ops complete in one cycle. SLL/SRL use a serial 1-bit-per-cycle shifter to save area.
- Provides a start/busy/done handshake so the controller can stall the pipeline during shifts.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHW, 5, shift-amount width; the maximum shift is 2^SHW-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled on a clk edge only when busy=0.
- alucontrol  in  4  operation code (encoding below).
- a  in  WIDTH  operand A (rs).
- b  in  WIDTH  operand B (rt/immediate); this is the value that gets shifted.
- shamt  in  SHW  shift amount, used by SLL/SRL only.
- busy  out  1  high while a serial shift is in progress.
- done  out  1  one-cycle pulse; result, zero and illegal are valid while done=1.
- result  out  WIDTH  registered result; holds until the next done.
- zero  out  1  registered; 1 when result==0.
- illegal  out  1  registered; 1 when the last completed op had an undefined code.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, busy=0, done=0, result=0, zero=1, illegal=0.
  - A shift in progress is aborted and no done is produced.
- States: IDLE, SHIFT.
- Encoding: 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 NOR, 0101 SRL, 0110 SUB, 0111 SLT (signed), 1000 XOR. Codes 1001-1111 are illegal.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
  - SLT gives result={0..,1} when $signed(a)<$signed(b), else 0.
  - SLL/SRL shift b by shamt; SRL is logical (zero fill).
- IDLE with start=1 at edge T:
  - Non-shift, or shift with shamt=0: result/zero/illegal are registered at edge T; done=1 for the cycle after T; stay in IDLE. A shift with shamt=0 returns b.
  - Illegal code: result=0, zero=1, illegal=1, done=1; latency 1.
  - Shift with shamt=N>0: load shift register from b, count=N, go to SHIFT, busy=1. done=0 at edge T.
- SHIFT:
  - Each edge shifts by 1 bit and decrements count.
  - At the edge where count goes 1->0, return to IDLE: busy=0, result=shifted value, zero updated, illegal=0, done=1 for that one cycle.
  - Latency from the start edge to done is N cycles; the busy-high span is N cycles.
  - Operands and alucontrol are captured at the start edge, so input changes during SHIFT have no effect.
- start while busy=1 is ignored: not queued, no error.
- A start in the cycle done=1 is legal (back-to-back); done can be high on consecutive cycles.
- done is 0 in every cycle not listed above.
- result/zero/illegal change only on edges that assert done (or on reset).

Test Plan:
1. Reset held, then released -> busy=0, done=0, result=0, zero=1, illegal=0. Assert reset mid-SHIFT (shamt=20, after 5 cycles) -> immediately busy=0; no done pulse follows.
2. ADD a=0x7FFFFFFF b=1 -> done after 1 cycle, result=0x80000000, zero=0. Then SUB a=5 b=5 back-to-back in the done cycle -> next cycle done=1, result=0, zero=1.
3. SLT a=0xFFFFFFFF b=1 -> result=1. SLT a=1 b=0xFFFFFFFF -> result=0. NOR a=0 b=0 -> result=0xFFFFFFFF. XOR a=0xF0F0F0F0 b=0xFFFF0000 -> result=0x0F0FF0F0.
4. SLL b=0x00000001 shamt=31 -> busy high for 31 cycles, done on the 31st cycle after start, result=0x80000000. A start pulse injected at cycle 10 is ignored.
5. SRL b=0x80000000 shamt=4 -> done 4 cycles after start, result=0x08000000. SRL shamt=0 b=0x1234 -> done after 1 cycle, result=0x1234, busy never asserted.
6. alucontrol=1011 with a=3 b=4 -> done after 1 cycle, illegal=1, result=0, zero=1. A following AND a=0xC b=0xA -> result=0x8, illegal=0.
